// File: rtl/atomic_fence_sequencer_pkg.sv
// Shared hazard codes and sequencer state encoding for atomic_fence_sequencer.
package atomic_fence_sequencer_pkg;

   localparam logic [3:0] HZ_NONE     = 4'd0;
   localparam logic [3:0] STALL_MMU   = 4'd4;
   localparam logic [3:0] FLUSH_EARLY = 4'd8;
   localparam logic [3:0] FLUSH_ALL   = 4'd9;

   typedef enum logic [2:0] {
      SEQ_IDLE     = 3'd0,
      SEQ_DRAIN    = 3'd1,
      SEQ_TLBFLUSH = 3'd2,
      SEQ_AMO_RD   = 3'd3,
      SEQ_AMO_WR   = 3'd4,
      SEQ_AMO_WB   = 3'd5
   } seq_state_t;

   function automatic logic is_flush_code(input logic [3:0] hz);
      return (hz == FLUSH_EARLY) || (hz == FLUSH_ALL);
   endfunction

endpackage

// File: rtl/seq_drain_timer.sv
// Fence drain timeout counter: load, decrement when enabled, expire at 1.
module seq_drain_timer #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             expired
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (dec && (cnt != '0))
         cnt <= cnt - 1'b1;
   end

   assign expired = (cnt == CNT_W'(1));

endmodule

// File: rtl/atomic_fence_sequencer.sv
// Sequences FENCE/FENCE.I/SFENCE.VMA drains and AMOSWAP.W read-then-write.
// Optional perf counters enabled by defining SEQ_PERF_CNT_EN.
module atomic_fence_sequencer
   import atomic_fence_sequencer_pkg::*;
#(
   parameter int unsigned DRAIN_TIMEOUT = 15,
   parameter int unsigned CNT_W         = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  hazard_signal,
   input  logic        fence_req,
   input  logic        fence_is_sfence,
   input  logic        swap_req,
   input  logic [31:0] amo_addr,
   input  logic [31:0] amo_wdata,
   input  logic [4:0]  amo_rd,
   input  logic        pipe_drained,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   input  logic        mem_fault,
   output logic        seq_stall,
   output logic        tlb_flush,
   output logic        amo_wb_valid,
   output logic [4:0]  amo_wb_rd,
   output logic [31:0] amo_wb_data,
   output logic        amo_fault
`ifdef SEQ_PERF_CNT_EN
   ,
   output logic [31:0] perf_fence_cycles,
   output logic [31:0] perf_amo_count,
   output logic [15:0] perf_drain_timeouts
`endif
);

   seq_state_t  state, state_n;
   logic [31:0] addr_q, wdata_q, rdata_q;
   logic [4:0]  rd_q;
   logic        sfence_q;
   logic        flush_pend, flush_pend_n;
   logic        timer_load, timer_dec, timer_expired;
   logic        lat_req, lat_rdata;
   logic        is_stall, is_flush, flushing, frozen;

   seq_drain_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (timer_load),
      .load_val (CNT_W'(DRAIN_TIMEOUT)),
      .dec      (timer_dec),
      .expired  (timer_expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= SEQ_IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         rd_q       <= '0;
         rdata_q    <= '0;
         sfence_q   <= 1'b0;
         flush_pend <= 1'b0;
      end else begin
         state      <= state_n;
         flush_pend <= flush_pend_n;
         if (timer_load)
            sfence_q <= fence_is_sfence;
         if (lat_req) begin
            addr_q  <= amo_addr;
            wdata_q <= amo_wdata;
            rd_q    <= amo_rd;
         end
         if (lat_rdata)
            rdata_q <= mem_rdata;
      end
   end

   // A flush seen during a memory beat is remembered so the beat can finish first.
   always_comb begin
      is_stall     = (hazard_signal == STALL_MMU);
      is_flush     = is_flush_code(hazard_signal);
      flushing     = is_flush || flush_pend;
      frozen       = is_stall && !flushing;
      state_n      = state;
      flush_pend_n = flush_pend;
      timer_load   = 1'b0;
      timer_dec    = 1'b0;
      lat_req      = 1'b0;
      lat_rdata    = 1'b0;
      seq_stall    = 1'b1;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      tlb_flush    = 1'b0;
      amo_wb_valid = 1'b0;
      amo_fault    = 1'b0;
      case (state)
         SEQ_IDLE: begin
            seq_stall = fence_req || swap_req;
            if (!is_flush && !is_stall) begin
               if (fence_req) begin
                  state_n    = SEQ_DRAIN;
                  timer_load = 1'b1;
               end else if (swap_req) begin
                  state_n = SEQ_AMO_RD;
                  lat_req = 1'b1;
               end
            end
         end
         SEQ_DRAIN: begin
            if (is_flush)
               state_n = SEQ_IDLE;
            else if (!is_stall) begin
               timer_dec = 1'b1;
               if (pipe_drained || timer_expired)
                  state_n = sfence_q ? SEQ_TLBFLUSH : SEQ_IDLE;
            end
         end
         SEQ_TLBFLUSH: begin
            if (is_flush)
               state_n = SEQ_IDLE;
            else if (!is_stall) begin
               tlb_flush = 1'b1;
               state_n   = SEQ_IDLE;
            end
         end
         SEQ_AMO_RD, SEQ_AMO_WR: begin
            mem_req = 1'b1;
            mem_we  = (state == SEQ_AMO_WR);
            if (is_flush)
               flush_pend_n = 1'b1;
            if (!frozen && mem_ready) begin
               if (flushing)
                  state_n = SEQ_IDLE;
               else if (mem_fault) begin
                  amo_fault = 1'b1;
                  state_n   = SEQ_IDLE;
               end else if (state == SEQ_AMO_RD) begin
                  lat_rdata = 1'b1;
                  state_n   = SEQ_AMO_WR;
               end else
                  state_n = SEQ_AMO_WB;
            end
         end
         SEQ_AMO_WB: begin
            if (is_flush)
               state_n = SEQ_IDLE;
            else if (!is_stall) begin
               amo_wb_valid = 1'b1;
               state_n      = SEQ_IDLE;
            end
         end
         default: state_n = SEQ_IDLE;
      endcase
      if (state_n == SEQ_IDLE)
         flush_pend_n = 1'b0;
   end

   assign mem_addr    = mem_req ? addr_q : '0;
   assign mem_wdata   = mem_we ? wdata_q : '0;
   assign amo_wb_rd   = amo_wb_valid ? rd_q : '0;
   assign amo_wb_data = amo_wb_valid ? rdata_q : '0;

`ifdef SEQ_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fence_cycles   <= '0;
         perf_amo_count      <= '0;
         perf_drain_timeouts <= '0;
      end else begin
         if (((state == SEQ_DRAIN) || (state == SEQ_TLBFLUSH)) && (perf_fence_cycles != '1))
            perf_fence_cycles <= perf_fence_cycles + 1'b1;
         if (amo_wb_valid && (perf_amo_count != '1))
            perf_amo_count <= perf_amo_count + 1'b1;
         if (timer_dec && timer_expired && !pipe_drained && (perf_drain_timeouts != '1))
            perf_drain_timeouts <= perf_drain_timeouts + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_atomic_fence_sequencer.sv
// Directed self-checking bench for atomic_fence_sequencer.
module tb_atomic_fence_sequencer;
   import atomic_fence_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  hazard_signal;
   logic        fence_req, fence_is_sfence, swap_req;
   logic [31:0] amo_addr, amo_wdata;
   logic [4:0]  amo_rd;
   logic        pipe_drained;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        mem_fault;
   logic        seq_stall, tlb_flush, amo_wb_valid, amo_fault;
   logic [4:0]  amo_wb_rd;
   logic [31:0] amo_wb_data;

   int total = 0;
   int bad   = 0;
   int stalls, pulses;

   always #5 clk = ~clk;

   atomic_fence_sequencer #(.DRAIN_TIMEOUT(15), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .hazard_signal(hazard_signal),
      .fence_req(fence_req), .fence_is_sfence(fence_is_sfence), .swap_req(swap_req),
      .amo_addr(amo_addr), .amo_wdata(amo_wdata), .amo_rd(amo_rd),
      .pipe_drained(pipe_drained),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_fault(mem_fault),
      .seq_stall(seq_stall), .tlb_flush(tlb_flush), .amo_wb_valid(amo_wb_valid),
      .amo_wb_rd(amo_wb_rd), .amo_wb_data(amo_wb_data), .amo_fault(amo_fault)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; hazard_signal = HZ_NONE;
      fence_req = 0; fence_is_sfence = 0; swap_req = 0;
      amo_addr = '0; amo_wdata = '0; amo_rd = '0; pipe_drained = 0;
      mem_ready = 0; mem_rdata = '0; mem_fault = 0;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_stall", seq_stall, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_pulses", {tlb_flush, amo_wb_valid, amo_fault}, 0);
      rst = 1'b0;

      // FENCE, pipe drains in third DRAIN cycle
      nxt(); fence_req = 1; #1; chk("fence_idle_stall", seq_stall, 1);
      nxt(); fence_req = 0; #1; chk("fence_drain1_stall", seq_stall, 1);
      nxt(); #1; chk("fence_drain2_stall", seq_stall, 1);
      nxt(); pipe_drained = 1; #1; chk("fence_drain3_stall", seq_stall, 1);
      chk("fence_drain3_tlb", tlb_flush, 0);
      nxt(); pipe_drained = 0; #1; chk("fence_done_stall", seq_stall, 0);
      chk("fence_done_tlb", tlb_flush, 0);

      // SFENCE, never drains: 15 DRAIN cycles then one tlb_flush
      nxt(); fence_req = 1; fence_is_sfence = 1; #1;
      nxt(); fence_req = 0; fence_is_sfence = 0;
      stalls = 0; pulses = 0;
      for (int i = 1; i <= 15; i++) begin
         if (i > 1) nxt();
         #1;
         stalls += int'(seq_stall);
         pulses += int'(tlb_flush);
      end
      chk("sfence_drain_stalls", stalls, 15);
      chk("sfence_drain_no_tlb", pulses, 0);
      nxt(); #1; chk("sfence_c16_tlb", tlb_flush, 1);
      chk("sfence_c16_stall", seq_stall, 1);
      nxt(); #1; chk("sfence_c17_tlb", tlb_flush, 0);
      chk("sfence_c17_stall", seq_stall, 0);

      // Flush during SFENCE drain: no tlb_flush
      nxt(); fence_req = 1; fence_is_sfence = 1; #1;
      nxt(); fence_req = 0; fence_is_sfence = 0; hazard_signal = FLUSH_EARLY; #1;
      nxt(); hazard_signal = HZ_NONE; #1;
      chk("flush_drain_stall", seq_stall, 0);
      chk("flush_drain_tlb", tlb_flush, 0);
      nxt(); #1; chk("flush_drain_tlb_later", tlb_flush, 0);

      // AMOSWAP zero-wait
      nxt(); swap_req = 1; amo_addr = 32'h100; amo_wdata = 32'hDEADBEEF; amo_rd = 5;
      mem_ready = 1; mem_rdata = 32'h12345678; #1;
      chk("amo_idle_stall", seq_stall, 1);
      chk("amo_idle_memreq", mem_req, 0);
      nxt(); swap_req = 0; amo_addr = 32'hFFFF_0000; amo_wdata = 32'h0; amo_rd = 9; #1;
      chk("amo_rd_req", {mem_req, mem_we}, 2'b10);
      chk("amo_rd_addr", mem_addr, 32'h100);
      nxt(); mem_rdata = 32'hCAFE_F00D; #1;
      chk("amo_wr_req", {mem_req, mem_we}, 2'b11);
      chk("amo_wr_addr", mem_addr, 32'h100);
      chk("amo_wr_data", mem_wdata, 32'hDEADBEEF);
      nxt(); mem_ready = 0; #1;
      chk("amo_wb_valid", amo_wb_valid, 1);
      chk("amo_wb_rd", amo_wb_rd, 5);
      chk("amo_wb_data", amo_wb_data, 32'h12345678);
      chk("amo_wb_memreq", mem_req, 0);
      nxt(); #1; chk("amo_done_wb", amo_wb_valid, 0);
      chk("amo_done_stall", seq_stall, 0);

      // Fault on read
      nxt(); swap_req = 1; amo_addr = 32'h200; #1;
      nxt(); swap_req = 0; mem_ready = 1; mem_fault = 1; #1;
      chk("fault_pulse", amo_fault, 1);
      chk("fault_rd_we", {mem_req, mem_we}, 2'b10);
      nxt(); mem_ready = 0; mem_fault = 0; #1;
      chk("fault_after_memreq", mem_req, 0);
      chk("fault_after_pulse", amo_fault, 0);
      chk("fault_after_stall", seq_stall, 0);

      // FLUSH_ALL in AMO_RD, ready delayed 2 cycles
      nxt(); swap_req = 1; amo_addr = 32'h300; amo_rd = 3; #1;
      nxt(); swap_req = 0; hazard_signal = FLUSH_ALL; #1;
      chk("flushrd_req1", {mem_req, mem_we}, 2'b10);
      nxt(); hazard_signal = HZ_NONE; #1;
      chk("flushrd_req2", {mem_req, mem_we}, 2'b10);
      nxt(); mem_ready = 1; mem_rdata = 32'hAAAA_5555; #1;
      chk("flushrd_req3", {mem_req, mem_we}, 2'b10);
      nxt(); mem_ready = 0; #1;
      chk("flushrd_no_write", mem_req, 0);
      chk("flushrd_no_wb", amo_wb_valid, 0);
      chk("flushrd_idle", seq_stall, 0);
      nxt(); #1; chk("flushrd_later", {mem_req, amo_wb_valid}, 0);

      // STALL_MMU 4 cycles in AMO_WB
      nxt(); swap_req = 1; amo_addr = 32'h400; amo_wdata = 32'h11; amo_rd = 7;
      mem_ready = 1; mem_rdata = 32'h22; #1;
      nxt(); swap_req = 0; #1;
      nxt(); #1;
      chk("stallwb_wr", {mem_req, mem_we}, 2'b11);
      stalls = 0; pulses = 0;
      for (int i = 0; i < 4; i++) begin
         nxt(); mem_ready = 0; hazard_signal = STALL_MMU; #1;
         stalls += int'(seq_stall);
         pulses += int'(amo_wb_valid);
      end
      chk("stallwb_held_stall", stalls, 4);
      chk("stallwb_deferred", pulses, 0);
      nxt(); hazard_signal = HZ_NONE; #1;
      chk("stallwb_release_valid", amo_wb_valid, 1);
      chk("stallwb_release_rd", amo_wb_rd, 7);
      chk("stallwb_release_data", amo_wb_data, 32'h22);
      nxt(); #1; chk("stallwb_once", amo_wb_valid, 0);

      // fence and swap together: fence wins
      nxt(); fence_req = 1; swap_req = 1; pipe_drained = 1; #1;
      nxt(); fence_req = 0; swap_req = 0; #1;
      chk("prio_no_memreq", mem_req, 0);
      chk("prio_stall", seq_stall, 1);
      nxt(); pipe_drained = 0; #1; chk("prio_idle", {seq_stall, mem_req}, 0);

      // async reset mid-AMO
      nxt(); swap_req = 1; amo_addr = 32'h500; #1;
      nxt(); swap_req = 0; #1; chk("rstmid_before", mem_req, 1);
      rst = 1; #1; chk("rstmid_memreq", mem_req, 0);
      nxt(); rst = 0; #1; chk("rstmid_idle", seq_stall, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
